// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit order, logical pattern table and code-to-pattern decode
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [SEG_W-1:0] seg7_pattern(input logic [3:0] code, input logic hex);
    return (code > 4'd9 && !hex) ? SEG_BLANK : SEG_TABLE[code];
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: code plus hex mode to active-high segment pattern {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       code,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] pattern
);
  assign pattern = seg7_pattern(code, hex_mode);
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit scanned 7-seg driver, frame-synchronous load; SEG7_DIM_EN adds duty dimming
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    load,
`ifdef SEG7_DIM_EN
  input  logic [3:0]              duty,
`endif
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  localparam logic AN_INV = AN_ACTIVE_LOW != 0;
  localparam logic HEX = HEX_MODE != 0;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic pending_q, pending_d, frame_q, frame_d, dp_q, dp_d;
  logic [SEG_W-1:0] seg_q, seg_d, pat;
  logic [NUM_DIGITS-1:0] an_q, an_d, onehot;
  logic [NUM_DIGITS:0] lz;
  logic tick, wrap, blank, lit;
  logic [3:0] code;
  assign lz[NUM_DIGITS] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign lz[g] = lz[g+1] && ~|disp_dig_q[4*g +: 4];
  end
`ifdef SEG7_DIM_EN
  assign lit = 32'(presc_q) < ((32'(duty) + 32'd1) * 32'(CLK_DIV)) / 32'd16;
`else
  assign lit = 1'b1;
`endif
  seg7_decode u_dec (.code(code), .hex_mode(HEX), .pattern(pat));
  always_comb begin
    tick = presc_q == PW'(CLK_DIV - 1);
    wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    frame_d = wrap;
    pend_dig_d = load ? digits : pend_dig_q;
    pend_dp_d = load ? dp_in : pend_dp_q;
    pending_d = wrap ? 1'b0 : (load || pending_q);
    disp_dig_d = (wrap && load) ? digits : (wrap && pending_q) ? pend_dig_q : disp_dig_q;
    disp_dp_d = (wrap && load) ? dp_in : (wrap && pending_q) ? pend_dp_q : disp_dp_q;
    code = disp_dig_q[4*idx_q +: 4];
    blank = blank_lz && idx_q != '0 && lz[idx_q];
    onehot = '0;
    onehot[idx_q] = 1'b1;
    seg_d = {SEG_W{SEG_INV}} ^ (blank ? SEG_BLANK : pat);
    dp_d = SEG_INV ^ (disp_dp_q[idx_q] && !blank);
    an_d = {NUM_DIGITS{AN_INV}} ^ (lit ? onehot : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q <= '0;
      disp_dig_q <= '0;
      disp_dp_q <= '0;
      pend_dig_q <= '0;
      pend_dp_q <= '0;
      pending_q <= 1'b0;
      frame_q <= 1'b0;
      seg_q <= {SEG_W{SEG_INV}};
      dp_q <= SEG_INV;
      an_q <= {NUM_DIGITS{AN_INV}};
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q <= disp_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q <= pend_dp_d;
      pending_q <= pending_d;
      frame_q <= frame_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp = dp_q;
  assign an = an_q;
  assign frame_done = frame_q;
  assign pending = pending_q;
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Multiplexed N-digit 7-segment display driver: the parametrised successor of the single-digit BCD decoder.
- Latches a packed BCD/hex word and scans the digits one at a time on a time-shared segment bus.
- Adds optional hex decode, leading-zero blanking, per-digit decimal points, configurable polarities and frame-synchronous update.
- Sits between datapath/counter logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 50000, clk cycles per digit slot (>=2)
HEX_MODE, 0, 1: codes 10-15 decode A,b,C,d,E,F; 0: codes 10-15 blank
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit
AN_ACTIVE_LOW, 1, 1: an driven low = digit enabled

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous reset, active-high
digits  in  4*NUM_DIGITS  packed codes, digit 0 = bits[3:0] (rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  enable leading-zero blanking
load  in  1  capture digits/dp_in into pending register
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point of current digit
an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the last digit slot ends
pending  out  1  captured load not yet displayed

Behaviour:
- Reset (rst=1 at clk edge): prescaler=0, index=0, display and pending registers=0, pending=0, frame_done=0, seg/dp/an all inactive.
- Prescaler counts 0..CLK_DIV-1. tick=1 when prescaler==CLK_DIV-1; the prescaler wraps to 0 on that cycle.
- On tick, index advances by 1 and wraps NUM_DIGITS-1 -> 0. frame_done pulses on the wrapping tick only.
- Outputs are registered from index and the display register; latency 1 clk after index changes.
- an is exactly one-hot (active) for the selected index; never more than one digit enabled.
- load=1: digits/dp_in are copied to the pending register and pending=1. A load while pending=1 overwrites the pending data.
- Display update happens at frame boundary only (the wrapping tick):
  - If pending=1: the display register takes the pending register and pending clears.
  - If load and the wrapping tick coincide: the new inputs go straight to display and pending stays 0.
- Decode, logical active-high values: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
  - HEX_MODE=0: codes 10-15 give 00 (blank).
  - Output is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked when its code and all higher digits' codes are 0. Digit 0 is never blanked.
  - A blanked digit shows seg=off and dp=off, but its an is still enabled.
- NUM_DIGITS=1: index stays 0 and frame_done pulses every tick.
- Reset mid-frame discards both the pending and displayed data.

Optional Feature:
SEG7_DIM_EN
- Defined: adds port duty in 4 (brightness). Within each slot, an is active only while prescaler < ((duty+1)*CLK_DIV)/16; seg still follows the digit. duty=15 gives full on.
- Undefined: no duty port; an is active for the whole slot.

Decomposition:
- Package seg7_pkg: segment bit-order constants, SEG_BLANK, the 16-entry logical pattern table, and the code->pattern function.
- Sub-module seg7_decode: combinational code+hex_mode -> 7-bit logical pattern. Instantiated once on the muxed digit. Polarity is applied in the parent.

Test Plan:
- Reset, CLK_DIV=4, NUM_DIGITS=4 -> an sequence 1110,1101,1011,0111 (active-low), each held 4 clk; frame_done pulses once every 16 clk.
- load digits=16'h1234 mid-frame -> display unchanged until the wrap; next frame shows seg 7'b0011001 on digit0 ("4"), pending 1->0 at the wrap.
- HEX_MODE=0, digits=16'h00AF, blank_lz=0 -> digits 0 and 1 show 7'h7F (blank); HEX_MODE=1 -> F=7'b0001110, A=7'b0001000.
- blank_lz=1, digits=16'h0050 -> digits 3,2 blank, digit1 "5", digit0 "0"; digits=16'h0000 -> only digit0 shows "0".
- load asserted exactly on the wrapping tick -> new data displayed in the immediately following frame, pending stays 0; two loads before the wrap -> the second value is displayed.
- rst asserted mid-slot with pending=1 -> next clk: an all 1, seg 7'h7F, pending 0; scanning restarts at digit0.
